// File: rtl/ddk_wb_pkg.sv
// Shared constants for the Wishbone FIFO slave: register map, STATUS bit
// positions and CTRL bit positions.
package ddk_wb_pkg;

    // Register addresses
    localparam logic [7:0] ADR_DATA   = 8'h00;
    localparam logic [7:0] ADR_STATUS = 8'h01;
    localparam logic [7:0] ADR_COUNT  = 8'h02;
    localparam logic [7:0] ADR_CTRL   = 8'h03;

    // STATUS register bit indices
    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_UNDERFLOW = 2;
    localparam int STATUS_OVERFLOW  = 3;

    // CTRL register bit indices
    localparam int CTRL_FLUSH = 0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush. A pop on a full FIFO frees the slot
// for a same-cycle push; a pop on an empty FIFO never bypasses the push.
// Flush overrides everything and discards a same-cycle push silently.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     push_data,
    output logic [DATA_W-1:0]     head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  push_drop,
    output logic                  pop_fail
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  do_push, do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    assign do_pop    = pop && !empty && !flush;
    assign do_push   = push && !flush && (!full || do_pop);
    assign push_drop = push && !flush && full && !do_pop;
    assign pop_fail  = pop && !flush && empty;

    // Occupancy follows accepted pushes and pops; flush empties it
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
                if (do_push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone-style byte slave in front of a sync_fifo: bus decode, sticky
// overflow/underflow flags and the registered ack/read-data outputs.
module wb_fifo_slave
    import ddk_wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8,
    parameter int ADR_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    output logic              full_o,
    output logic              empty_o
);

    logic                  rd_req, wr_req;
    logic                  sel_data, sel_status, sel_count, sel_ctrl;
    logic                  bus_push, bus_drop, fifo_push, flush;
    logic [DATA_W-1:0]     fifo_push_data, head, status, rd_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  push_drop, pop_fail, full, empty;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  ack_reg;
    logic [DATA_W-1:0]     dat_reg, dat_next;

    assign rd_req     = stb_i && !we_i;
    assign wr_req     = stb_i && we_i;
    assign sel_data   = (adr_i == ADR_W'(ADR_DATA));
    assign sel_status = (adr_i == ADR_W'(ADR_STATUS));
    assign sel_count  = (adr_i == ADR_W'(ADR_COUNT));
    assign sel_ctrl   = (adr_i == ADR_W'(ADR_CTRL));

    // Producer port has priority over a loopback write to DATA
    assign bus_push       = wr_req && sel_data && !push_i;
    assign bus_drop       = wr_req && sel_data && push_i;
    assign fifo_push      = push_i || bus_push;
    assign fifo_push_data = push_i ? push_dat_i : dat_i;
    assign flush          = wr_req && sel_ctrl && dat_i[CTRL_FLUSH];

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (fifo_push),
        .pop       (rd_req && sel_data),
        .flush     (flush),
        .push_data (fifo_push_data),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_drop (push_drop),
        .pop_fail  (pop_fail)
    );

    assign full_o  = full;
    assign empty_o = empty;
    assign ack_o   = ack_reg;
    assign dat_o   = dat_reg;

    // Read mux and next read-data; dat_o holds while the bus is idle
    always_comb begin
        status                   = '0;
        status[STATUS_EMPTY]     = empty;
        status[STATUS_FULL]      = full;
        status[STATUS_UNDERFLOW] = underflow_reg;
        status[STATUS_OVERFLOW]  = overflow_reg;

        rd_data = '0;
        if (sel_data)        rd_data = pop_fail ? '0 : head;
        else if (sel_status) rd_data = status;
        else if (sel_count)  rd_data = DATA_W'(count);

        dat_next = dat_reg;
        if (stb_i) dat_next = rd_req ? rd_data : '0;
    end

    // Sticky flags: W1C clear first, then a same-cycle set wins
    always_comb begin
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (wr_req && sel_status && dat_i[STATUS_OVERFLOW])  overflow_next  = 1'b0;
        if (wr_req && sel_status && dat_i[STATUS_UNDERFLOW]) underflow_next = 1'b0;
        if (push_drop || bus_drop) overflow_next  = 1'b1;
        if (pop_fail)              underflow_next = 1'b1;
    end

    // Bus response and flag registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_reg       <= 1'b0;
            dat_reg       <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ack_reg       <= stb_i;
            dat_reg       <= dat_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Bench for wb_fifo_slave: constant vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_wb_fifo_slave;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       stb_i, we_i, push_i;
    logic [7:0] adr_i, dat_i, push_dat_i;
    logic [7:0] dat_o;
    logic       ack_o, full_o, empty_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ov, m_uf;
    logic [7:0] m_dat;
    bit         m_known;

    typedef struct {
        bit         stb;
        bit         we;
        logic [7:0] adr;
        logic [7:0] dat;
        bit         push;
        logic [7:0] pdat;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    wb_fifo_slave dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .ack_o      (ack_o),
        .push_i     (push_i),
        .push_dat_i (push_dat_i),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_ov    = 0;
        m_uf    = 0;
        m_dat   = 8'h00;
        m_known = 1;
    endtask

    function automatic void add(input bit stb, input bit we, input logic [7:0] adr,
                                input logic [7:0] dat, input bit push,
                                input logic [7:0] pdat, input logic [7:0] exp);
        vec_t v;
        v.stb = stb; v.we = we; v.adr = adr; v.dat = dat;
        v.push = push; v.pdat = pdat; v.exp = exp;
        tbl.push_back(v);
    endfunction

    // One bus cycle: drive, predict with the model, compare after the edge.
    // use_const selects a hand-derived expected read value instead of the model's.
    task automatic cyc(input bit stb, input bit we, input logic [7:0] adr,
                       input logic [7:0] dat, input bit push, input logic [7:0] pdat,
                       input bit use_const, input logic [7:0] cexp, input string name);
        int         sz;
        bit         popped, ov_set, uf_set, flush, has;
        logic [7:0] nd, v;
        bit         nk;
        sz = q.size();
        popped = 0; ov_set = 0; uf_set = 0; flush = 0; has = 0;
        nd = m_dat; nk = m_known; v = 8'h00;
        if (stb && !we) begin
            nk = 1;
            case (adr)
                8'h00: begin
                    if (sz == 0) begin nd = 8'h00; uf_set = 1; end
                    else begin nd = q[0]; popped = 1; end
                end
                8'h01:   nd = {4'b0000, m_ov, m_uf, sz == 16, sz == 0};
                8'h02:   nd = 8'(sz);
                default: nd = 8'h00;
            endcase
        end else if (stb && we) begin
            if (adr <= 8'h03) nk = 0;
            else begin nd = 8'h00; nk = 1; end
            flush = (adr == 8'h03) && dat[0];
        end

        stb_i = stb; we_i = we; adr_i = adr; dat_i = dat;
        push_i = push; push_dat_i = pdat;
        @(posedge clk_i);
        #1;

        if (popped) void'(q.pop_front());
        if (flush) q.delete();
        else begin
            if (push) begin
                has = 1; v = pdat;
                if (stb && we && adr == 8'h00) ov_set = 1;
            end else if (stb && we && adr == 8'h00) begin
                has = 1; v = dat;
            end
            if (has) begin
                if (sz < 16 || popped) q.push_back(v);
                else ov_set = 1;
            end
        end
        if (stb && we && adr == 8'h01) begin
            if (dat[2]) m_uf = 0;
            if (dat[3]) m_ov = 0;
        end
        if (uf_set) m_uf = 1;
        if (ov_set) m_ov = 1;
        m_dat = nd; m_known = nk;

        chk({name, " ack"}, 32'(ack_o), 32'(stb));
        if (nk) chk({name, " dat"}, 32'(dat_o), use_const ? 32'(cexp) : 32'(nd));
        chk({name, " full"}, 32'(full_o), 32'(q.size() == 16));
        chk({name, " empty"}, 32'(empty_o), 32'(q.size() == 0));
    endtask

    initial begin
        int unsigned r;
        bit         rs, rw, rp;
        logic [7:0] ra, rd;

        rst_i = 1'b0;
        stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0; push_i = 0; push_dat_i = 0;
        model_reset();
        #12;
        chk("reset ack", 32'(ack_o), 32'd0);
        chk("reset dat", 32'(dat_o), 32'h00);
        chk("reset empty", 32'(empty_o), 32'd1);
        chk("reset full", 32'(full_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // stb we adr dat push pdat exp
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h01);
        add(1, 0, 8'h02, 8'h00, 0, 8'h00, 8'h00);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        add(0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h00);
        add(0, 0, 8'h00, 8'h00, 1, 8'h3C, 8'h00);
        add(0, 0, 8'h00, 8'h00, 1, 8'h7E, 8'h00);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'hA5);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h3C);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h7E);
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h7E);
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h01);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h05);
        add(1, 1, 8'h01, 8'h04, 0, 8'h00, 8'h00);
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h01);
        add(1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 8'h00, 1, 8'(8'h11 + i), 8'h00);
        add(1, 0, 8'h02, 8'h00, 0, 8'h00, 8'h05);
        add(1, 1, 8'h03, 8'h01, 0, 8'h00, 8'h00);
        add(1, 0, 8'h02, 8'h00, 0, 8'h00, 8'h00);
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h01);
        add(1, 1, 8'h00, 8'h9C, 0, 8'h00, 8'h00);
        add(1, 0, 8'h02, 8'h00, 0, 8'h00, 8'h01);
        add(1, 1, 8'h00, 8'h77, 1, 8'h42, 8'h00);
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h08);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h9C);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h42);
        add(1, 1, 8'h01, 8'h08, 0, 8'h00, 8'h00);
        add(1, 0, 8'h01, 8'h00, 0, 8'h00, 8'h01);
        add(1, 1, 8'h20, 8'hFF, 0, 8'h00, 8'h00);

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].push,
                tbl[i].pdat, 1, tbl[i].exp, $sformatf("vec%0d", i));

        // Fill to 16, then overflow with a 17th push
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 8'h00, 8'h00, 1, 8'(i), 0, 8'h00, $sformatf("fill%0d", i));
            if (i >= 15) chk($sformatf("full after push %0d", i + 1), 32'(full_o), 32'd1);
        end
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h0A, "status full+ovf");
        cyc(1, 1, 8'h01, 8'h08, 0, 8'h00, 1, 8'h00, "clear ovf");
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h02, "status full");
        // Push while full with a same-cycle pop: both succeed
        cyc(1, 0, 8'h00, 8'h00, 1, 8'h55, 1, 8'h00, "full push+pop");
        cyc(1, 0, 8'h02, 8'h00, 0, 8'h00, 1, 8'h10, "count stays 16");
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h02, "no ovf on push+pop");
        for (int i = 1; i < 16; i++)
            cyc(1, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'(i), $sformatf("drain%0d", i));
        cyc(1, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h55, "last is 0x55");
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h01, "status drained");
        // Empty: pop underflows while push succeeds, no bypass
        cyc(1, 0, 8'h00, 8'h00, 1, 8'hC3, 1, 8'h00, "empty push+pop");
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h04, "status uf+1");
        // Flush with a same-cycle push: push discarded, no overflow
        cyc(1, 1, 8'h03, 8'h01, 1, 8'hEE, 1, 8'h00, "flush+push");
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h05, "status after flush");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(5, 0);
            ra = (r < 2) ? 8'h00 : (r < 5) ? 8'(r - 1) : 8'($urandom_range(255, 4));
            rs = ($urandom_range(3, 0) != 0);
            rw = ($urandom_range(2, 0) == 0);
            rd = 8'($urandom);
            if (ra == 8'h03) rd[0] = ($urandom_range(7, 0) == 0);
            rp = ($urandom_range(1, 0) == 1);
            cyc(rs, rw, ra, rd, rp, 8'($urandom), 0, 8'h00, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a held-stb burst
        cyc(1, 1, 8'h03, 8'h01, 0, 8'h00, 0, 8'h00, "pre-flush");
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 8'h00, 1, 8'(i + 8'h60), 0, 8'h00, "pre-push");
        cyc(1, 0, 8'h02, 8'h00, 0, 8'h00, 1, 8'h05, "burst count");
        cyc(1, 0, 8'h02, 8'h00, 0, 8'h00, 1, 8'h05, "burst count2");
        #2 rst_i = 1'b0;
        #1;
        chk("async reset ack", 32'(ack_o), 32'd0);
        chk("async reset dat", 32'(dat_o), 32'h00);
        chk("async reset empty", 32'(empty_o), 32'd1);
        model_reset();
        #3 rst_i = 1'b1;
        cyc(1, 0, 8'h02, 8'h00, 0, 8'h00, 1, 8'h00, "count after reset");
        cyc(1, 0, 8'h01, 8'h00, 0, 8'h00, 1, 8'h01, "status after reset");
        cyc(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h01, "idle hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
